// File: rtl/serial_adder_ctrl.sv
// Wide unsigned adder built by running one 2-bit adder slice per cycle, LSB slice first,
// with a registered carry between slices and valid/ready handshakes on both sides.

module two_bit_adder (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] sum,
  output logic       cout
);

  logic [2:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {2'b00, cin};
  assign sum   = total[1:0];
  assign cout  = total[2];

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICES = WIDTH / 2;
  localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NSLICES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'(3);

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
      $error("serial_adder_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [1:0]       slice_sum;
  logic             slice_cout;
  logic [IDX_W:0]   shamt;

  two_bit_adder u_slice (
    .a    (a_q[1:0]),
    .b    (b_q[1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Slice idx lands at bit 2*idx of the result
  assign shamt = {idx_q, 1'b0};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~(SLICE_MASK << shamt)) | (WIDTH'(slice_sum) << shamt);
        carry_d = slice_cout;
        a_d     = a_q >> 2;
        b_d     = b_q >> 2;
        idx_d   = idx_q + IDX_ONE;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for handshake, carry,
// backpressure, abort and random sums, plus a 2-bit instance swept exhaustively.

module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       cin_in = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] sum;
  logic       cout;
  logic       busy;

  logic       in_valid2 = 1'b0;
  logic       in_ready2;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       cin2 = 1'b0;
  logic       out_valid2;
  logic       out_ready2 = 1'b0;
  logic [1:0] sum2;
  logic       cout2;
  logic       busy2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .b         (b_in),
    .cin       (cin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a2),
    .b         (b2),
    .cin       (cin2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .sum       (sum2),
    .cout      (cout2),
    .busy      (busy2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; returns rising edges between accept and out_valid
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                               output int lat, output logic busy_run);
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("in_ready_before_req", 32'(in_ready), 32'd1);
    a_in     = av;
    b_in     = bv;
    cin_in   = cv;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    busy_run = busy;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int         lat;
    logic       busy_run;
    logic [8:0] expv;
    logic [7:0] ra, rb;
    logic       rc;
    logic [2:0] exp2;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_sum", 32'(sum), 32'h00);
    checkOutput("reset_cout", 32'(cout), 32'd0);

    applyStimulus(8'h5A, 8'h33, 1'b0, lat, busy_run);
    checkOutput("basic_latency", 32'(lat), 32'd4);
    checkOutput("basic_busy_run", 32'(busy_run), 32'd1);
    checkOutput("basic_busy_done", 32'(busy), 32'd1);
    checkOutput("basic_sum", 32'(sum), 32'h8D);
    checkOutput("basic_cout", 32'(cout), 32'd0);

    // Backpressure with a competing request that must not be captured
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_in      = 8'h11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_sum", 32'(sum), 32'h8D);
      checkOutput("bp_cout", 32'(cout), 32'd0);
    end
    in_valid = 1'b0;
    consume();
    checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_holds_sum", 32'(sum), 32'h8D);

    applyStimulus(8'hFF, 8'h01, 1'b0, lat, busy_run);
    checkOutput("carry1_latency", 32'(lat), 32'd4);
    checkOutput("carry1_sum", 32'(sum), 32'h00);
    checkOutput("carry1_cout", 32'(cout), 32'd1);
    consume();

    applyStimulus(8'hFF, 8'hFF, 1'b1, lat, busy_run);
    checkOutput("carry2_sum", 32'(sum), 32'hFF);
    checkOutput("carry2_cout", 32'(cout), 32'd1);
    consume();

    applyStimulus(8'h00, 8'h00, 1'b1, lat, busy_run);
    checkOutput("carry3_sum", 32'(sum), 32'h01);
    checkOutput("carry3_cout", 32'(cout), 32'd0);
    consume();

    // Abort two cycles into RUN
    a_in     = 8'hAA;
    b_in     = 8'h55;
    cin_in   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_sum", 32'(sum), 32'h00);
    checkOutput("abort_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_no_valid", 32'(out_valid), 32'd0);

    applyStimulus(8'h10, 8'h20, 1'b1, lat, busy_run);
    checkOutput("post_abort_latency", 32'(lat), 32'd4);
    checkOutput("post_abort_sum", 32'(sum), 32'h31);
    checkOutput("post_abort_cout", 32'(cout), 32'd0);
    consume();

    for (int n = 0; n < 500; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      expv = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(ra, rb, rc, lat, busy_run);
      checkOutput("rand_latency", 32'(lat), 32'd4);
      checkOutput("rand_sum", 32'(sum), 32'(expv[7:0]));
      checkOutput("rand_cout", 32'(cout), 32'(expv[8]));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      consume();
    end

    for (int i = 0; i < 32; i++) begin
      logic [4:0] combo;
      combo = 5'(i);
      a2    = combo[4:3];
      b2    = combo[2:1];
      cin2  = combo[0];
      exp2  = {1'b0, combo[4:3]} + {1'b0, combo[2:1]} + {2'b00, combo[0]};
      checkOutput("w2_in_ready", 32'(in_ready2), 32'd1);
      in_valid2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid2 = 1'b0;
      checkOutput("w2_run_not_valid", 32'(out_valid2), 32'd0);
      @(negedge clk);
      checkOutput("w2_valid_1edge", 32'(out_valid2), 32'd1);
      checkOutput("w2_sum", 32'(sum2), 32'(exp2[1:0]));
      checkOutput("w2_cout", 32'(cout2), 32'(exp2[2]));
      out_ready2 = 1'b1;
      @(negedge clk);
      out_ready2 = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
